// File: rtl/rdat_poll_sched_if.sv
// rdat_poll_sched_if: read channel towards the 3WI engine plus the downstream
// valid/ready frame channel. The scheduler uses the master modport.
interface rdat_poll_sched_if #(
   parameter int unsigned FRAME_W = 52
);
   // 3WI read channel
   logic               rd_req;
   logic [2:0]         rd_sel;
   logic               rd_ack;
   logic [FRAME_W-1:0] rd_frame;

   // Downstream frame channel
   logic               out_valid;
   logic               out_ready;
   logic [FRAME_W-1:0] out_data;
   logic [2:0]         out_asc;

   modport master (
      output rd_req, rd_sel, out_valid, out_data, out_asc,
      input  rd_ack, rd_frame, out_ready
   );

   modport slave (
      input  rd_req, rd_sel, out_valid, out_data, out_asc,
      output rd_ack, rd_frame, out_ready
   );
endinterface

// File: rtl/rdat_poll_sched.sv
// rdat_poll_sched: round-robin RDAT poller sharing one 3WI read channel among up
// to 8 ASC devices. Each enabled slot gets a read request; the returned frame is
// handed downstream over valid/ready, or a sticky timeout flag is raised.
// Optional feature: define RDAT_PARITY_CHK_EN to check even parity held in
// rd_frame[FRAME_W-1], drop bad frames and flag them in parity_err.
module rdat_poll_sched #(
   parameter int unsigned ASC_COUNT   = 8,
   parameter int unsigned FRAME_W     = 52,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned GAP_CYC     = 4
) (
   input  logic              clk_3wi,
   input  logic              rst_3wi,
   input  logic              poll_en,
   input  logic [7:0]        asc_mask,
   input  logic              err_clr,
   output logic [7:0]        timeout_err,
`ifdef RDAT_PARITY_CHK_EN
   output logic [7:0]        parity_err,
`endif
   output logic              busy,
   rdat_poll_sched_if.master bus
);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StPresent, StGap} state_t;

   localparam logic [7:0] SLOT_MASK   = 8'((32'd1 << ASC_COUNT) - 32'd1);
   localparam logic [2:0] LAST_SLOT   = 3'(ASC_COUNT - 1);
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
   localparam logic [3:0] GAP_LIM     = 4'(GAP_CYC);

   state_t             state_q, state_d;
   logic [2:0]         sel_q, sel_d;
   logic [2:0]         ptr_q, ptr_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [3:0]         gap_q, gap_d;
   logic [FRAME_W-1:0] data_q, data_d;
   logic [2:0]         asc_q, asc_d;
   logic [7:0]         tout_q, tout_d;
`ifdef RDAT_PARITY_CHK_EN
   logic [7:0]         par_q, par_d;
   logic               par_bad;
`endif

   logic [7:0]         valid_mask;
   logic               start;
   logic [2:0]         next_ptr;
   logic [2:0]         base;
   logic [2:0]         pick;
   logic [2:0]         idx;
   logic               found;

   assign valid_mask = asc_mask & SLOT_MASK;
   assign start      = poll_en & (|valid_mask);
   assign next_ptr   = (sel_q == LAST_SLOT) ? 3'd0 : sel_q + 3'd1;
   // In GAP the pointer is being advanced this cycle, so search from its new value.
   assign base       = (state_q == StGap) ? next_ptr : ptr_q;
`ifdef RDAT_PARITY_CHK_EN
   // Frame plus its parity bit must XOR to zero.
   assign par_bad    = ^bus.rd_frame;
`endif

   // Pick the first enabled slot at or after base, wrapping 7 -> 0.
   always_comb begin
      pick  = base;
      found = 1'b0;
      idx   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         idx = base + 3'(i);
         if (!found && valid_mask[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // Next-state logic for the poll FSM and its datapath.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      data_d  = data_q;
      asc_d   = asc_q;
      // Clear first so a same-cycle set below wins.
      tout_d  = err_clr ? 8'd0 : tout_q;
`ifdef RDAT_PARITY_CHK_EN
      par_d   = err_clr ? 8'd0 : par_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               sel_d   = pick;
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = 8'd0;
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + 8'd1;
            // An ack in the final wait cycle beats the timeout.
            if (bus.rd_ack) begin
               gap_d = 4'd0;
`ifdef RDAT_PARITY_CHK_EN
               if (par_bad) begin
                  par_d[sel_q] = 1'b1;
                  state_d      = StGap;
               end else begin
                  data_d  = bus.rd_frame;
                  asc_d   = sel_q;
                  state_d = StPresent;
               end
`else
               data_d  = bus.rd_frame;
               asc_d   = sel_q;
               state_d = StPresent;
`endif
            end else if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
               tout_d[sel_q] = 1'b1;
               gap_d         = 4'd0;
               state_d       = StGap;
            end
         end
         StPresent: begin
            if (bus.out_ready) begin
               gap_d   = 4'd0;
               state_d = StGap;
            end
         end
         StGap: begin
            // One pointer-update cycle followed by GAP_CYC idle cycles.
            ptr_d = next_ptr;
            if (gap_q == GAP_LIM) begin
               if (start) begin
                  sel_d   = pick;
                  state_d = StIssue;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_3wi) begin
      if (rst_3wi) begin
         state_q <= StIdle;
         sel_q   <= 3'd0;
         ptr_q   <= 3'd0;
         cnt_q   <= 8'd0;
         gap_q   <= 4'd0;
         data_q  <= '0;
         asc_q   <= 3'd0;
         tout_q  <= 8'd0;
`ifdef RDAT_PARITY_CHK_EN
         par_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         asc_q   <= asc_d;
         tout_q  <= tout_d;
`ifdef RDAT_PARITY_CHK_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.rd_req    = (state_q == StIssue);
   assign bus.rd_sel    = sel_q;
   assign bus.out_valid = (state_q == StPresent);
   assign bus.out_data  = data_q;
   assign bus.out_asc   = asc_q;
   assign timeout_err   = tout_q;
`ifdef RDAT_PARITY_CHK_EN
   assign parity_err    = par_q;
`endif
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_rdat_poll_sched.sv
// tb_rdat_poll_sched: directed plus randomized bench for rdat_poll_sched with a
// transaction-level reference model (round-robin pick, expected flags, timing).
module tb_rdat_poll_sched;

   localparam int ASC_COUNT   = 8;
   localparam int FW          = 52;
   localparam int TIMEOUT_CYC = 255;
   localparam int GAP_CYC     = 4;

   logic       clk;
   logic       rst;
   logic       poll_en;
   logic [7:0] asc_mask;
   logic       err_clr;
   logic [7:0] timeout_err;
   logic       busy;
`ifdef RDAT_PARITY_CHK_EN
   logic [7:0] parity_err;
   logic [7:0] exp_par;
`endif

   rdat_poll_sched_if #(.FRAME_W(FW)) bus ();

   rdat_poll_sched #(
      .ASC_COUNT  (ASC_COUNT),
      .FRAME_W    (FW),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .GAP_CYC    (GAP_CYC)
   ) dut (
      .clk_3wi    (clk),
      .rst_3wi    (rst),
      .poll_en    (poll_en),
      .asc_mask   (asc_mask),
      .err_clr    (err_clr),
      .timeout_err(timeout_err),
`ifdef RDAT_PARITY_CHK_EN
      .parity_err (parity_err),
`endif
      .busy       (busy),
      .bus        (bus)
   );

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;
   int cyc      = 0;

   // Reference model state
   int          ptr;
   logic [7:0]  exp_tout;
   logic [FW-1:0] exp_last;
   int          last_req_cyc;
   int          exp_interval;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first enabled slot at or after p, wrapping past 7.
   function automatic int model_pick(input int p, input logic [7:0] m);
      for (int k = 0; k < 8; k++) begin
         int s;
         s = (p + k) % 8;
         if (s < ASC_COUNT && m[s]) return s;
      end
      return -1;
   endfunction

   function automatic logic [FW-1:0] mk_frame();
      logic [63:0] r;
      logic [FW-1:0] f;
      r = {$urandom, $urandom};
      f = r[FW-1:0];
`ifdef RDAT_PARITY_CHK_EN
      f[FW-1] = ^f[FW-2:0];
`endif
      return f;
   endfunction

   task automatic next_req();
      int n;
      n = 0;
      while (bus.rd_req !== 1'b1 && n < 600) begin
         step();
         n++;
      end
      check("rd_req seen", bus.rd_req, 1);
      check("req interval", cyc - last_req_cyc, exp_interval);
      last_req_cyc = cyc;
   endtask

   // One full transaction, entered at the ISSUE cycle, left at the first GAP cycle.
   // lat > TIMEOUT_CYC means the engine never acks.
   task automatic txn(input int lat, input int stall = 0, input bit clr_last = 0,
                      input bit drop_en = 0, input bit fix_en = 0,
                      input logic [FW-1:0] fix_frame = '0, input bit flip = 0);
      int sel;
      logic [FW-1:0] frame;
      bit ok;
      bit vseen;
      sel   = model_pick(ptr, asc_mask);
      ok    = 1'b1;
      vseen = 1'b0;
      check("rd_req", bus.rd_req, 1);
      check("rd_sel", bus.rd_sel, sel);
      out_ready_set(stall == 0);
      step();
      check("rd_req pulse", bus.rd_req, 0);
      if (drop_en) poll_en = 1'b0;
      ok    &= (bus.rd_sel == 3'(sel));
      vseen |= bus.out_valid;
      if (lat <= TIMEOUT_CYC) begin
         for (int k = 1; k < lat; k++) begin
            step();
            ok    &= (bus.rd_sel == 3'(sel));
            vseen |= bus.out_valid;
         end
         frame = fix_en ? fix_frame : mk_frame();
         if (flip) frame[FW-1] = ~frame[FW-1];
         bus.rd_ack   = 1'b1;
         bus.rd_frame = frame;
         step();
         bus.rd_ack   = 1'b0;
         bus.rd_frame = mk_frame();
         check("rd_sel stable", ok, 1);
         check("no early valid", vseen, 0);
         check("timeout_err ack", timeout_err, exp_tout);
         ptr = (sel + 1) % ASC_COUNT;
`ifdef RDAT_PARITY_CHK_EN
         if (^frame) begin
            exp_par[sel] = 1'b1;
            check("parity drop", bus.out_valid, 0);
            check("parity_err", parity_err, exp_par);
            exp_interval = 1 + lat + GAP_CYC + 1;
         end else
`endif
         begin
            check("out_valid", bus.out_valid, 1);
            check("out_data", bus.out_data, frame);
            check("out_asc", bus.out_asc, sel);
            for (int s = 0; s < stall; s++) begin
               step();
               check("hold valid", bus.out_valid, 1);
               check("hold data", bus.out_data, frame);
            end
            out_ready_set(1'b1);
            step();
            check("valid drop", bus.out_valid, 0);
            exp_last     = frame;
            exp_interval = 1 + lat + stall + 1 + GAP_CYC + 1;
         end
      end else begin
         for (int k = 1; k < TIMEOUT_CYC; k++) begin
            step();
            ok    &= (bus.rd_sel == 3'(sel));
            vseen |= bus.out_valid;
         end
         check("timeout_err pre", timeout_err, exp_tout);
         if (clr_last) err_clr = 1'b1;
         step();
         err_clr = 1'b0;
         if (clr_last) exp_tout = 8'd0;
         exp_tout[sel] = 1'b1;
         check("rd_sel stable", ok, 1);
         check("timeout no valid", vseen | bus.out_valid, 0);
         check("timeout_err", timeout_err, exp_tout);
         ptr          = (sel + 1) % ASC_COUNT;
         exp_interval = 1 + TIMEOUT_CYC + GAP_CYC + 1;
      end
      out_ready_set(1'b1);
   endtask

   task automatic out_ready_set(input bit v);
      bus.out_ready = v;
   endtask

   initial begin
      int n_req;
      rst          = 1'b1;
      poll_en      = 1'b0;
      asc_mask     = 8'h00;
      err_clr      = 1'b0;
      bus.rd_ack   = 1'b0;
      bus.rd_frame = '0;
      bus.out_ready = 1'b1;
      ptr          = 0;
      exp_tout     = 8'd0;
      exp_last     = '0;
`ifdef RDAT_PARITY_CHK_EN
      exp_par      = 8'd0;
`endif
      step();
      step();
      // Reset values
      check("rst rd_req", bus.rd_req, 0);
      check("rst rd_sel", bus.rd_sel, 0);
      check("rst out_valid", bus.out_valid, 0);
      check("rst out_data", bus.out_data, 0);
      check("rst out_asc", bus.out_asc, 0);
      check("rst timeout_err", timeout_err, 0);
      check("rst busy", busy, 0);
      rst = 1'b0;
      step();
      check("idle busy", busy, 0);

      // Slots 0 and 2, ack latency 3, consumer always ready
      poll_en      = 1'b1;
      asc_mask     = 8'h05;
      last_req_cyc = cyc;
      exp_interval = 1;
      for (int t = 0; t < 4; t++) begin
         next_req();
         txn(3);
      end
      // Spurious ack in GAP must not touch the held frame
      bus.rd_ack   = 1'b1;
      bus.rd_frame = ~exp_last;
      step();
      bus.rd_ack   = 1'b0;
      check("spurious ack", bus.out_data, exp_last);

      // Slot 1 never answers
      asc_mask = 8'h02;
      next_req();
      txn(TIMEOUT_CYC + 1);
      // Slot 3 times out in the same cycle err_clr is pulsed: set wins
      asc_mask = 8'h0A;
      next_req();
      txn(TIMEOUT_CYC + 1, 0, 1'b1);
      err_clr = 1'b1;
      step();
      err_clr  = 1'b0;
      exp_tout = 8'd0;
      check("err_clr", timeout_err, exp_tout);

      // Ack in the very last wait cycle wins over the timeout
      asc_mask = 8'h08;
      next_req();
      txn(TIMEOUT_CYC);
      // Long consumer stall on a fixed frame
      next_req();
      txn(3, 20, 1'b0, 1'b0, 1'b1, 52'hA_BCDE_F012_3456);

      // poll_en dropped during WAIT: finish, then go idle
      asc_mask = 8'h02;
      next_req();
      txn(3, 0, 1'b0, 1'b1);
      check("busy in gap", busy, 1);
      repeat (GAP_CYC + 1) step();
      check("idle after drop", busy, 0);
      n_req = 0;
      repeat (20) begin
         step();
         n_req += int'(bus.rd_req);
      end
      check("no req when idle", n_req, 0);

      // Reset while a frame is being presented
      poll_en      = 1'b1;
      asc_mask     = 8'h81;
      last_req_cyc = cyc;
      exp_interval = 1;
      next_req();
      check("rd_sel pre-reset", bus.rd_sel, model_pick(ptr, asc_mask));
      repeat (2) step();
      bus.rd_ack    = 1'b1;
      bus.rd_frame  = mk_frame();
      bus.out_ready = 1'b0;
      step();
      bus.rd_ack = 1'b0;
      check("valid pre-reset", bus.out_valid, 1);
      rst = 1'b1;
      step();
      check("reset drops valid", bus.out_valid, 0);
      check("reset busy", busy, 0);
      check("reset out_data", bus.out_data, 0);
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      ptr           = 0;
      last_req_cyc  = cyc;
      exp_interval  = 1;
      next_req();
      txn(2);

      // Randomized masks, latencies and stalls
      for (int t = 0; t < 12; t++) begin
         asc_mask = 8'($urandom_range(1, 255));
         next_req();
         txn(int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
      end

`ifdef RDAT_PARITY_CHK_EN
      // Bad parity from slot 4 is dropped, good parity is presented
      asc_mask = 8'h10;
      next_req();
      txn(3, 0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      next_req();
      txn(4);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      exp_par = 8'd0;
      check("parity clr", parity_err, exp_par);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
